traffic_light_ctrl: RTL and testbench
=====================================

Name: traffic_light_ctrl

Overview:
Timed traffic-light sequencer. It generates the 2-bit traffic_state code (00 RED, 01 GREEN, 10 YELLOW) that the gate controller decodes into CLOSE, OPEN and WAIT.
- Built-in prescaler produces a phase tick.
- Per-phase down-counters set the RED, GREEN and YELLOW durations.
- Inputs allow an early-green request and an emergency hold.
- Sits upstream of the gate logic at the top level.

Parameters:
TICK_DIV, 50000000, clk cycles per phase tick (≥2)
RED_T, 10, RED duration in ticks (1..2^CNT_W-1)
GREEN_T, 8, GREEN duration in ticks (1..2^CNT_W-1)
YELLOW_T, 3, YELLOW duration in ticks (1..2^CNT_W-1)
REQ_MIN, 2, RED remaining-time floor applied on req (≥1)
CNT_W, 8, width of remain counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
enable  input  1  1 = prescaler runs; 0 = timing frozen
req  input  1  level; request early GREEN while in RED
hold  input  1  level; emergency, force sequence to RED and stay there
traffic_state  output  2  00 RED, 01 GREEN, 10 YELLOW; 11 never driven
remain  output  CNT_W  ticks left in current phase, including the current one
phase_done  output  1  one-cycle pulse in the cycle after a phase change

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high. All outputs are registered.
- Reset values:
  - traffic_state=00 (RED)
  - remain=RED_T
  - prescaler=0
  - phase_done=0
- First tick comes TICK_DIV enabled cycles after rst deasserts.
- Prescaler:
  - Counts 0..TICK_DIV-1 while enable=1, then wraps to 0.
  - tick=1 in the cycle the count equals TICK_DIV-1 and enable=1.
  - When enable=0 the prescaler holds its value and no tick occurs.
- Phase counter, on a tick:
  - If remain>1: decrement remain.
  - If remain==1: advance state and load the next phase's duration into remain.
  - Sequence: RED→GREEN (GREEN_T), GREEN→YELLOW (YELLOW_T), YELLOW→RED (RED_T).
- phase_done: pulses 1 for exactly the first cycle in which the new traffic_state is visible. This applies to every transition, including those caused by hold and req.
- req (sampled every clk, independent of tick):
  - Acts only in RED with hold=0 and remain>REQ_MIN: sets remain=REQ_MIN next cycle. Prescaler is unaffected.
  - In GREEN or YELLOW, or in RED with remain≤REQ_MIN: ignored.
- hold (sampled every clk, acts regardless of enable and tick):
  - In GREEN: next cycle goes to YELLOW, remain=YELLOW_T.
  - In YELLOW: normal countdown continues, then RED.
  - In RED: remain is frozen; ticks do not decrement it and no exit to GREEN occurs.
  - On release in RED, countdown resumes from the frozen remain.
- Simultaneous events:
  - hold beats req.
  - hold asserted in GREEN in the same cycle as a tick with remain==1 → YELLOW; only one phase_done pulse.
  - req in the same cycle as a RED tick: req's load wins (remain=REQ_MIN); the tick's decrement is discarded.
- Illegal state 11 (SEU or otherwise) recovers to RED with remain=RED_T next cycle.
- Reset mid-phase: immediate return to reset values; no phase_done pulse.

Test Plan:
All tests use TICK_DIV=4, RED_T=3, GREEN_T=2, YELLOW_T=1, REQ_MIN=1, enable=1, req=hold=0 unless stated.

1. Release rst at cycle 0, free run:
   - RED for cycles 0–11, GREEN for 12–19, YELLOW for 20–23, RED from 24.
   - remain sequence in RED: 3, 2, 1.
   - phase_done high exactly at cycles 12, 20 and 24.
2. Assert hold at cycle 14 (GREEN):
   - Cycle 15: traffic_state=10, remain=1, phase_done=1.
   - RED from the next tick.
   - RED holds with remain=3 while hold=1.
   - After release, GREEN 12 cycles later.
3. Pulse req at cycle 1 (RED, remain=3):
   - Cycle 2: remain=1.
   - GREEN at the first tick (cycle 4).
   - A second req pulse at cycle 5 (GREEN) has no effect.
4. Drop enable for cycles 5–14 during RED:
   - traffic_state and remain frozen.
   - GREEN is delayed by exactly 10 cycles, to cycle 22.
5. Assert rst at cycle 17 (GREEN) for 1 cycle, asynchronously mid-cycle:
   - Outputs go to RED/remain=3/phase_done=0 before the next clk edge.
   - Sequence restarts as in test 1.
6. Force the state register to 11 via the bench:
   - Next cycle traffic_state=00, remain=3.
   - traffic_state never reads 11 at any sampled edge.

Source files
------------

// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the traffic-light sequencer and whatever drives it.
// The controller side takes the slave modport; the stimulus/upstream side
// takes the master modport.
interface traffic_light_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             req;
    logic             hold;
    logic [1:0]       traffic_state;
    logic [CNT_W-1:0] remain;
    logic             phase_done;

    modport master (
        output enable,
        output req,
        output hold,
        input  traffic_state,
        input  remain,
        input  phase_done
    );

    modport slave (
        input  enable,
        input  req,
        input  hold,
        output traffic_state,
        output remain,
        output phase_done
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Timed traffic-light sequencer: RED -> GREEN -> YELLOW -> RED.
// A prescaler turns clk into a phase tick; a down-counter holds the ticks
// left in the current phase. req shortens RED, hold forces the sequence
// into RED and parks it there. All outputs come straight from flops.
module traffic_light_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int RED_T    = 10,
    parameter int GREEN_T  = 8,
    parameter int YELLOW_T = 3,
    parameter int REQ_MIN  = 2,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    traffic_light_ctrl_if.slave  tl
);

    localparam int               PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]    PRESC_ONE = PW'(1);
    localparam logic [CNT_W-1:0] RED_L     = CNT_W'(RED_T);
    localparam logic [CNT_W-1:0] GREEN_L   = CNT_W'(GREEN_T);
    localparam logic [CNT_W-1:0] YELLOW_L  = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] REQ_L     = CNT_W'(REQ_MIN);
    localparam logic [CNT_W-1:0] ONE_L     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RED    = 2'b00,
        ST_GREEN  = 2'b01,
        ST_YELLOW = 2'b10
    } state_t;

    // The state register is kept as a raw 2-bit vector so that the
    // unused code 2'b11 is representable and can be recovered from.
    logic [PW-1:0]    presc_r;
    logic [PW-1:0]    presc_nxt_s;
    logic             tick_s;
    logic [1:0]       state_r;
    state_t           state_nxt_s;
    logic [1:0]       out_state_r;
    logic [CNT_W-1:0] remain_r;
    logic [CNT_W-1:0] remain_nxt_s;
    logic             phase_done_r;
    logic             phase_done_nxt_s;

    // Prescaler next value and phase tick; frozen whenever enable is low.
    always_comb begin
        presc_nxt_s = presc_r;
        tick_s      = 1'b0;
        if (tl.enable) begin
            if (presc_r == PRESC_MAX) begin
                presc_nxt_s = {PW{1'b0}};
                tick_s      = 1'b1;
            end else begin
                presc_nxt_s = presc_r + PRESC_ONE;
            end
        end else begin
            presc_nxt_s = presc_r;
        end
    end

    // Phase sequencing: hold outranks req, req outranks the tick, and an
    // illegal state code falls back to a fresh RED phase.
    always_comb begin
        state_nxt_s  = ST_RED;
        remain_nxt_s = remain_r;
        case (state_r)
            ST_RED: begin
                state_nxt_s = ST_RED;
                if (tl.hold) begin
                    remain_nxt_s = remain_r;
                end else if (tl.req && (remain_r > REQ_L)) begin
                    remain_nxt_s = REQ_L;
                end else if (tick_s) begin
                    if (remain_r > ONE_L) begin
                        remain_nxt_s = remain_r - ONE_L;
                    end else begin
                        state_nxt_s  = ST_GREEN;
                        remain_nxt_s = GREEN_L;
                    end
                end else begin
                    remain_nxt_s = remain_r;
                end
            end
            ST_GREEN: begin
                state_nxt_s = ST_GREEN;
                if (tl.hold) begin
                    state_nxt_s  = ST_YELLOW;
                    remain_nxt_s = YELLOW_L;
                end else if (tick_s) begin
                    if (remain_r > ONE_L) begin
                        remain_nxt_s = remain_r - ONE_L;
                    end else begin
                        state_nxt_s  = ST_YELLOW;
                        remain_nxt_s = YELLOW_L;
                    end
                end else begin
                    remain_nxt_s = remain_r;
                end
            end
            ST_YELLOW: begin
                state_nxt_s = ST_YELLOW;
                if (tick_s) begin
                    if (remain_r > ONE_L) begin
                        remain_nxt_s = remain_r - ONE_L;
                    end else begin
                        state_nxt_s  = ST_RED;
                        remain_nxt_s = RED_L;
                    end
                end else begin
                    remain_nxt_s = remain_r;
                end
            end
            default: begin
                state_nxt_s  = ST_RED;
                remain_nxt_s = RED_L;
            end
        endcase
        // Pulse whenever the visible light code is about to change.
        phase_done_nxt_s = (2'(state_nxt_s) != out_state_r);
    end

    // Prescaler count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= {PW{1'b0}};
        end else begin
            presc_r <= presc_nxt_s;
        end
    end

    // Sequencer state plus separately registered outputs; the output copy
    // never holds 2'b11 even if the internal state register is upset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= 2'(ST_RED);
            out_state_r  <= 2'(ST_RED);
            remain_r     <= RED_L;
            phase_done_r <= 1'b0;
        end else begin
            state_r      <= 2'(state_nxt_s);
            out_state_r  <= 2'(state_nxt_s);
            remain_r     <= remain_nxt_s;
            phase_done_r <= phase_done_nxt_s;
        end
    end

    assign tl.traffic_state = out_state_r;
    assign tl.remain        = remain_r;
    assign tl.phase_done    = phase_done_r;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: directed scenarios with
// literal cycle expectations, then randomized req/hold/enable traffic
// checked every cycle against a phase-table reference model.
module tb_traffic_light_ctrl;

    localparam int TICK_DIV = 4;
    localparam int RED_T    = 3;
    localparam int GREEN_T  = 2;
    localparam int YELLOW_T = 1;
    localparam int REQ_MIN  = 1;
    localparam int CNT_W    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: phase index 0/1/2 = RED/GREEN/YELLOW, durations by table.
    int dur [3];
    int m_phase, m_rem, m_presc, m_pd;
    bit seu_q;

    traffic_light_ctrl_if #(.CNT_W(CNT_W)) tl ();

    traffic_light_ctrl #(
        .TICK_DIV(TICK_DIV), .RED_T(RED_T), .GREEN_T(GREEN_T),
        .YELLOW_T(YELLOW_T), .REQ_MIN(REQ_MIN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tl (tl)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_rem   = dur[0];
        m_presc = 0;
        m_pd    = 0;
        seu_q   = 1'b0;
        cyc     = 0;
    endtask

    // Advance one clock: predict from the current inputs, then compare.
    task automatic step();
        int  np, nr, npr;
        bit  tk;
        tk  = tl.enable && (m_presc == TICK_DIV - 1);
        npr = tl.enable ? (m_presc + 1) % TICK_DIV : m_presc;
        np  = m_phase;
        nr  = m_rem;
        if (seu_q) begin
            np = 0;
            nr = dur[0];
        end else if (m_phase == 0 && tl.hold) begin
            nr = m_rem;
        end else if (m_phase == 0 && tl.req && m_rem > REQ_MIN) begin
            nr = REQ_MIN;
        end else if (m_phase == 1 && tl.hold) begin
            np = 2;
            nr = dur[2];
        end else if (tk) begin
            if (m_rem > 1) begin
                nr = m_rem - 1;
            end else begin
                np = (m_phase + 1) % 3;
                nr = dur[np];
            end
        end
        m_pd = (np != m_phase) ? 1 : 0;
        @(posedge clk);
        #1;
        m_phase = np;
        m_rem   = nr;
        m_presc = npr;
        seu_q   = 1'b0;
        cyc++;
        check_eq("state", tl.traffic_state, m_phase);
        check_eq("remain", tl.remain, m_rem);
        check_eq("phase_done", tl.phase_done, m_pd);
    endtask

    task automatic run_until(input int c);
        while (cyc < c) step();
    endtask

    // Reset through one clock edge, checking the reset values while asserted.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tl.enable = 1'b1;
        tl.req    = 1'b0;
        tl.hold   = 1'b0;
        #1;
        check_eq("rst_state", tl.traffic_state, 0);
        check_eq("rst_remain", tl.remain, RED_T);
        check_eq("rst_phase_done", tl.phase_done, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic int free_state(input int c);
        if (c < 12)      return 0;
        else if (c < 20) return 1;
        else if (c < 24) return 2;
        else             return 0;
    endfunction

    // Free run from reset compared with the literal timeline.
    task automatic run_free(input int n);
        repeat (n) begin
            step();
            check_eq("free_state", tl.traffic_state, free_state(cyc));
            check_eq("free_pd", tl.phase_done,
                     (cyc == 12 || cyc == 20 || cyc == 24) ? 1 : 0);
            if (cyc < 12) check_eq("free_remain", tl.remain, 3 - cyc / 4);
        end
    endtask

    initial begin
        dur[0] = RED_T;
        dur[1] = GREEN_T;
        dur[2] = YELLOW_T;
        tl.enable = 1'b1;
        tl.req    = 1'b0;
        tl.hold   = 1'b0;

        // Free run.
        do_reset();
        run_free(30);

        // hold in GREEN, park in RED, release aligned to prescaler zero.
        do_reset();
        run_until(14);
        tl.hold = 1'b1;
        step();
        check_eq("hold_y_state", tl.traffic_state, 2);
        check_eq("hold_y_remain", tl.remain, 1);
        check_eq("hold_y_pd", tl.phase_done, 1);
        run_until(36);
        check_eq("hold_red_state", tl.traffic_state, 0);
        check_eq("hold_red_remain", tl.remain, 3);
        tl.hold = 1'b0;
        run_until(47);
        check_eq("rel_still_red", tl.traffic_state, 0);
        step();
        check_eq("rel_green", tl.traffic_state, 1);
        check_eq("rel_green_pd", tl.phase_done, 1);

        // Early-green request, then a req in GREEN that must be ignored.
        do_reset();
        run_until(1);
        tl.req = 1'b1;
        step();
        check_eq("req_remain", tl.remain, 1);
        tl.req = 1'b0;
        run_until(4);
        check_eq("req_green", tl.traffic_state, 1);
        check_eq("req_green_pd", tl.phase_done, 1);
        step();
        tl.req = 1'b1;
        step();
        tl.req = 1'b0;
        check_eq("req_ign_state", tl.traffic_state, 1);
        check_eq("req_ign_remain", tl.remain, 2);

        // enable low for cycles 5..14 delays GREEN to cycle 22.
        do_reset();
        run_until(5);
        tl.enable = 1'b0;
        run_until(15);
        check_eq("en_frozen_remain", tl.remain, 2);
        tl.enable = 1'b1;
        run_until(21);
        check_eq("en_still_red", tl.traffic_state, 0);
        step();
        check_eq("en_green", tl.traffic_state, 1);

        // Asynchronous reset mid-cycle during GREEN.
        do_reset();
        run_until(17);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_state", tl.traffic_state, 0);
        check_eq("arst_remain", tl.remain, RED_T);
        check_eq("arst_pd", tl.phase_done, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        run_free(30);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            tl.enable = (($urandom % 8) != 0);
            tl.req    = (($urandom % 6) == 0);
            if (($urandom % 16) == 0) tl.hold = ~tl.hold;
            if (($urandom % 400) == 0) do_reset();
            step();
        end

        // Upset the state register to the unused code while in GREEN.
        do_reset();
        run_until(14);
        @(negedge clk);
        force dut.state_r = 2'b11;
        seu_q = 1'b1;
        step();
        check_eq("seu_state", tl.traffic_state, 0);
        check_eq("seu_remain", tl.remain, RED_T);
        @(negedge clk);
        release dut.state_r;
        do_reset();
        run_free(14);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
